fifo_rd_fwft: RTL and testbench
===============================

# fifo_rd_fwft

Read-domain controller for the async FIFO. It owns the binary/Gray read pointer, derives `empty`/`almost_empty`/level from the synchronized Gray write pointer, and drives the FIFO memory's synchronous read port. Read data reaches the consumer through a 2-entry first-word-fall-through output buffer with a valid/ready handshake. It pairs with the write-domain controller and sits between the FIFO memory and the read-side consumer.

## Interface
- `P_SIZE`, 4: pointer width; memory depth is 2^(P_SIZE-1).
- `D_WIDTH`, 8: data width.
- `AE_LEVEL`, 1: `almost_empty` is asserted when memory level ≤ AE_LEVEL.
- `r_clk`  in  1  read-domain clock; the only clock.
- `r_rstn`  in  1  reset, synchronous, active-low.
- `sync_wr_ptr`  in  P_SIZE  Gray write pointer, already synchronized into r_clk.
- `r_en`  out  1  memory read enable.
- `r_addr`  out  P_SIZE-1  memory read address; equals `r_ptr[P_SIZE-2:0]`.
- `r_mem_data`  in  D_WIDTH  memory read data; valid the cycle after `r_en`.
- `gray_r_ptr`  out  P_SIZE  registered Gray read pointer, sent to the write-domain synchronizer.
- `r_data`  out  D_WIDTH  head of the output buffer.
- `r_valid`  out  1  `r_data` is valid.
- `r_ready`  in  1  consumer accepts `r_data`.
- `empty`  out  1  memory holds no unread entries, as seen by the read domain.
- `almost_empty`  out  1  memory level ≤ AE_LEVEL.
- `r_level`  out  P_SIZE  registered memory occupancy, 0..2^(P_SIZE-1).

## Operation
- **Pointer**
  - `r_ptr` is a P_SIZE-bit binary pointer that increments on every cycle with `r_en`=1 and wraps naturally.
  - `gray_r_ptr` is registered from `gray(r_ptr_next)`, so it always equals `gray(r_ptr)`; there is no extra lag.
- **Flags**
  - `empty` = (`gray(r_ptr)` == `sync_wr_ptr`). It is combinational on registered state.
  - `wr_bin` = gray2bin(`sync_wr_ptr`).
  - `r_level` is registered each cycle from `wr_bin - r_ptr`, computed modulo 2^P_SIZE.
  - `almost_empty` = (`r_level` ≤ AE_LEVEL) OR `empty`.
- **Handshake and buffer**
  - A pop occurs when `r_valid` && `r_ready`.
  - `pending` is a flag set the cycle after `r_en`; it marks a read in flight.
  - Issue rule: `r_en` = !`empty` && (`buf_cnt` + `pending` − pop) < 2.
  - When `pending`=1, `r_mem_data` is written into the buffer at the tail. A write and a pop in the same cycle are legal.
  - The buffer is 2 entries. `r_data` is the head entry and `r_valid` = (`buf_cnt` ≠ 0).
  - The buffer never overflows; the issue rule guarantees `buf_cnt` + `pending` ≤ 2.
- **Backpressure:** while `r_ready`=0, `r_data`/`r_valid` hold stable and no read is issued once `buf_cnt` + `pending` = 2.
- **Reset**
  - All pointers, `pending`, and `buf_cnt` clear; `gray_r_ptr`=0, `r_level`=0, `r_valid`=0, `r_en`=0.
  - `empty` follows `sync_wr_ptr`, and is 1 while `sync_wr_ptr`=0.
  - A read in flight when reset asserts is discarded.

## Timing
- Latency from `empty` going low (cycle 0, `r_en`=1) to `r_valid`=1 is cycle 2.
- Sustained throughput is 1 word/cycle when `r_ready`=1 and the memory is not empty.
- `r_level` lags `sync_wr_ptr`/`r_ptr` by 1 cycle. Because `r_level` lags, `almost_empty` is conservative only via the `empty` term.
- Pointer wrap: after 2^P_SIZE reads, `r_ptr` returns to 0. `empty` stays correct because full-width Gray compare distinguishes laps.
- Simultaneous write arrival and final read: `empty` evaluates against the updated `r_ptr` next cycle, so there is no over-read.

## Structure
- Shared package `fifo_pkg`:
  - `gray2bin` and `bin2gray` functions.
  - Default `P_SIZE`/`D_WIDTH` constants, shared with the write-side controller.
- Sub-module `fifo_rd_obuf`: 2-entry FWFT buffer with a push/pop interface and `buf_cnt` output. Top level holds pointer, flag, and issue logic.

## Test plan
- **Reset:** assert `r_rstn`=0 for 2 cycles with `sync_wr_ptr`=0. Check every output is 0 except `empty`=1 and `almost_empty`=1.
- **Single word:**
  - Drive memory word 0 = 8'hA5, then `sync_wr_ptr` → 4'b0001.
  - Expect `r_en`=1 with `r_addr`=0 at cycle 0, then `r_valid`=1 with `r_data`=8'hA5 at cycle 2.
  - After the pop, expect `empty`=1 and `gray_r_ptr`=4'b0001.
- **Full-rate burst:** 8 entries available, `r_ready`=1. Expect 8 consecutive `r_valid` beats in address order 0..7 with no gaps; `r_level` counts 8 down to 0.
- **Backpressure:**
  - 8 entries available, `r_ready`=0. Expect exactly 2 `r_en` pulses, then `r_en`=0 and `r_data` held at word 0.
  - Release `r_ready`; expect words 0..7 in order with no duplicates.
- **Wrap-around:** stream 40 words through the 8-deep memory with random `r_ready`. Check data order is preserved, `gray_r_ptr` stays one-bit-change per step, and `r_ptr` wraps at 16.
- **Mid-burst reset:** assert `r_rstn`=0 during a burst with `pending`=1. Expect `r_valid`=0 and `gray_r_ptr`=0 the next cycle, with no buffer write from the discarded read.

Source files
------------

// File: rtl/fifo_pkg.sv
// fifo_pkg: shared pointer-width defaults and Gray/binary conversion helpers for the async FIFO controllers
package fifo_pkg;
  localparam int P_SIZE_DEF = 4;
  localparam int D_WIDTH_DEF = 8;
  typedef logic [31:0] word_t;
  function automatic word_t bin2gray(input word_t b);
    return b ^ (b >> 1);
  endfunction
  function automatic word_t gray2bin(input word_t g);
    word_t b;
    b = g;
    for (int i = 1; i < 32; i++) b = b ^ (g >> i);
    return b;
  endfunction
endpackage

// File: rtl/fifo_rd_obuf.sv
// fifo_rd_obuf: 2-entry first-word-fall-through buffer; push_i/push_data_i write tail, pop_i drops head, data_o is head, cnt_o is occupancy
module fifo_rd_obuf #(
  parameter int D_WIDTH = 8
) (
  input  logic               clk_i,
  input  logic               rstn_i,
  input  logic               push_i,
  input  logic [D_WIDTH-1:0] push_data_i,
  input  logic               pop_i,
  output logic [D_WIDTH-1:0] data_o,
  output logic [1:0]         cnt_o
);
  logic [D_WIDTH-1:0] mem_q [2];
  logic               wr_q, rd_q;
  logic [1:0]         cnt_q;
  always_ff @(posedge clk_i) begin
    if (!rstn_i) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_q     <= 1'b0;
      rd_q     <= 1'b0;
      cnt_q    <= 2'd0;
    end else begin
      if (push_i) begin
        mem_q[wr_q] <= push_data_i;
        wr_q        <= !wr_q;
      end
      if (pop_i) rd_q <= !rd_q;
      cnt_q <= cnt_q + {1'b0, push_i} - {1'b0, pop_i};
    end
  end
  assign data_o = mem_q[rd_q];
  assign cnt_o  = cnt_q;
endmodule

// File: rtl/fifo_rd_fwft.sv
// fifo_rd_fwft: async FIFO read controller; r_clk/r_rstn, sync_wr_ptr in, memory port r_en/r_addr/r_mem_data, gray_r_ptr out, FWFT r_data/r_valid/r_ready, empty/almost_empty/r_level flags
module fifo_rd_fwft
  import fifo_pkg::*;
#(
  parameter int P_SIZE   = P_SIZE_DEF,
  parameter int D_WIDTH  = D_WIDTH_DEF,
  parameter int AE_LEVEL = 1
) (
  input  logic               r_clk,
  input  logic               r_rstn,
  input  logic [P_SIZE-1:0]  sync_wr_ptr,
  output logic               r_en,
  output logic [P_SIZE-2:0]  r_addr,
  input  logic [D_WIDTH-1:0] r_mem_data,
  output logic [P_SIZE-1:0]  gray_r_ptr,
  output logic [D_WIDTH-1:0] r_data,
  output logic               r_valid,
  input  logic               r_ready,
  output logic               empty,
  output logic               almost_empty,
  output logic [P_SIZE-1:0]  r_level
);
  logic [P_SIZE-1:0] r_ptr_q, r_ptr_d, gray_q, level_q;
  logic              pending_q, pop;
  logic [1:0]        buf_cnt;
  logic [2:0]        occ;
  assign pop          = r_valid && r_ready;
  assign occ          = {1'b0, buf_cnt} + 3'(pending_q) - 3'(pop);
  assign empty        = gray_q == sync_wr_ptr;
  assign r_en         = r_rstn && !empty && occ < 3'd2;
  assign r_ptr_d      = r_ptr_q + P_SIZE'(r_en);
  assign r_addr       = r_ptr_q[P_SIZE-2:0];
  assign gray_r_ptr   = gray_q;
  assign r_level      = level_q;
  assign almost_empty = level_q <= P_SIZE'(AE_LEVEL) || empty;
  always_ff @(posedge r_clk) begin
    if (!r_rstn) begin
      r_ptr_q   <= '0;
      gray_q    <= '0;
      level_q   <= '0;
      pending_q <= 1'b0;
    end else begin
      r_ptr_q   <= r_ptr_d;
      gray_q    <= P_SIZE'(bin2gray(32'(r_ptr_d)));
      level_q   <= P_SIZE'(gray2bin(32'(sync_wr_ptr))) - r_ptr_q;
      pending_q <= r_en;
    end
  end
  fifo_rd_obuf #(.D_WIDTH(D_WIDTH)) u_obuf (
    .clk_i      (r_clk),
    .rstn_i     (r_rstn),
    .push_i     (pending_q),
    .push_data_i(r_mem_data),
    .pop_i      (pop),
    .data_o     (r_data),
    .cnt_o      (buf_cnt)
  );
  assign r_valid = buf_cnt != 2'd0;
endmodule

// File: tb/tb_fifo_rd_fwft.sv
// tb_fifo_rd_fwft: randomized self-checking bench with a count-based reference model of the read controller
module tb_fifo_rd_fwft;
  logic       clk = 1'b0;
  logic       r_rstn, r_en, r_valid, r_ready, empty, almost_empty;
  logic [3:0] sync_wr_ptr, gray_r_ptr, r_level;
  logic [2:0] r_addr;
  logic [7:0] r_mem_data, r_data;
  logic [7:0] mem [8];
  logic [7:0] wdata [$];
  int         n_chk = 0, n_fail = 0;
  int         wr_cnt = 0, rd_cnt = 0, landed = 0, popped = 0, level_exp = 0;
  bit         chk_en = 0, ren_exp = 0, pop_exp = 0, empty_exp, valid_exp, prev_ok = 0;
  logic [3:0] prev_g = '0;

  always #5 clk = ~clk;

  fifo_rd_fwft dut (
    .r_clk(clk), .r_rstn(r_rstn), .sync_wr_ptr(sync_wr_ptr), .r_en(r_en), .r_addr(r_addr),
    .r_mem_data(r_mem_data), .gray_r_ptr(gray_r_ptr), .r_data(r_data), .r_valid(r_valid),
    .r_ready(r_ready), .empty(empty), .almost_empty(almost_empty), .r_level(r_level)
  );

  always @(posedge clk) if (r_en) r_mem_data <= mem[r_addr];

  function automatic logic [3:0] to_gray(int b);
    logic [3:0] x;
    x = 4'(b);
    return x ^ (x >> 1);
  endfunction

  task automatic check(string name, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic put(logic [7:0] d);
    mem[wr_cnt % 8] = d;
    wdata.push_back(d);
    wr_cnt++;
    sync_wr_ptr = to_gray(wr_cnt);
  endtask

  // Model: words issued, words landed in the buffer, words popped, all as plain counts.
  always @(negedge clk) if (chk_en) begin
    empty_exp = wr_cnt == rd_cnt;
    valid_exp = landed > popped;
    pop_exp   = valid_exp && r_ready;
    ren_exp   = r_rstn && !empty_exp && (rd_cnt - popped - int'(pop_exp)) < 2;
    check("r_en", r_en, ren_exp);
    if (ren_exp) check("r_addr", r_addr, rd_cnt % 8);
    check("gray_r_ptr", gray_r_ptr, to_gray(rd_cnt));
    check("empty", empty, empty_exp);
    check("r_level", r_level, level_exp);
    check("almost_empty", almost_empty, level_exp <= 1 || empty_exp);
    check("r_valid", r_valid, valid_exp);
    if (valid_exp) check("r_data", r_data, wdata[popped]);
    if (prev_ok) check("gray_step", $countones(gray_r_ptr ^ prev_g) <= 1, 1);
    prev_g  = gray_r_ptr;
    prev_ok = r_rstn;
  end

  always @(posedge clk) begin
    if (!r_rstn) begin
      rd_cnt = 0; landed = 0; popped = 0; level_exp = 0;
    end else begin
      level_exp = wr_cnt - rd_cnt;
      landed    = rd_cnt;
      rd_cnt   += int'(ren_exp);
      popped   += int'(pop_exp);
    end
  end

  initial begin
    int pulses, run, best, pops, written, budget;
    r_rstn = 0; sync_wr_ptr = '0; r_ready = 0;
    step(); chk_en = 1; step();
    @(negedge clk);
    check("rst_r_en", r_en, 0);
    check("rst_r_addr", r_addr, 0);
    check("rst_gray", gray_r_ptr, 0);
    check("rst_r_valid", r_valid, 0);
    check("rst_r_data", r_data, 0);
    check("rst_r_level", r_level, 0);
    check("rst_empty", empty, 1);
    check("rst_almost_empty", almost_empty, 1);
    step(); r_rstn = 1; r_ready = 1;
    step();
    put(8'hA5);
    @(negedge clk);
    check("sw_r_en", r_en, 1);
    check("sw_r_addr", r_addr, 0);
    step(); step();
    @(negedge clk);
    check("sw_r_valid", r_valid, 1);
    check("sw_r_data", r_data, 8'hA5);
    step();
    @(negedge clk);
    check("sw_empty", empty, 1);
    check("sw_gray", gray_r_ptr, 4'b0001);
    step();
    for (int i = 0; i < 8; i++) put(8'h30 + 8'(i));
    step();
    @(negedge clk);
    check("burst_level_start", r_level, 8);
    run = 0; best = 0;
    for (int i = 0; i < 14; i++) begin
      step();
      @(negedge clk);
      run  = r_valid ? run + 1 : 0;
      best = run > best ? run : best;
    end
    check("burst_beats", best, 8);
    check("burst_level_end", r_level, 0);
    step();
    r_ready = 0;
    for (int i = 0; i < 8; i++) put(8'h10 + 8'(i));
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      pulses += int'(r_en);
      step();
    end
    check("bp_pulses", pulses, 2);
    check("bp_r_valid", r_valid, 1);
    check("bp_r_data", r_data, 8'h10);
    r_ready = 1;
    pops = 0;
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      pops += int'(r_valid);
      step();
    end
    check("bp_pops", pops, 8);
    written = 0; budget = 0;
    while (popped < 57 && budget < 2000) begin
      r_ready = 1'($urandom_range(0, 1));
      if (written < 40 && wr_cnt - rd_cnt < 8 && $urandom_range(0, 1) == 1) begin
        put(8'($urandom));
        written++;
      end
      step();
      budget++;
    end
    check("wrap_budget", budget < 2000, 1);
    r_ready = 1;
    for (int i = 0; i < 4; i++) step();
    @(negedge clk);
    check("wrap_gray", gray_r_ptr, 4'b1101);
    check("wrap_empty", empty, 1);
    step();
    for (int i = 0; i < 6; i++) put(8'h60 + 8'(i));
    @(negedge clk);
    check("mr_r_en", r_en, 1);
    step();
    r_rstn = 0;
    step();
    @(negedge clk);
    check("mr_r_valid", r_valid, 0);
    check("mr_gray", gray_r_ptr, 0);
    check("mr_r_en", r_en, 0);
    check("mr_r_data", r_data, 0);
    wr_cnt = 0; wdata.delete(); sync_wr_ptr = '0;
    step();
    r_rstn = 1;
    written = 0; budget = 0;
    while (popped < 10 && budget < 1000) begin
      r_ready = 1'($urandom_range(0, 1));
      if (written < 10 && wr_cnt - rd_cnt < 8 && $urandom_range(0, 1) == 1) begin
        put(8'($urandom));
        written++;
      end
      step();
      budget++;
    end
    check("post_rst_budget", budget < 1000, 1);
    step();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
